// File: rtl/conway_pkg.sv
// Shared types and sizing helpers for the Game-of-Life board scan-out path.
package conway_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = ST_IDLE,
        STREAM = ST_STREAM
    } state_e;

    // Width able to hold every value 0..cells, i.e. a full-board population.
    function automatic int count_width(input int cells);
        return $clog2(cells + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cell_index(input int x, input int y, input int width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/board_scanout_if.sv
// Cell stream from the scan-out block to its consumer: one cell per beat, framed by SOF/EOL/EOF.
interface board_scanout_if;

    logic out_valid;
    logic out_ready;
    logic out_cell;
    logic out_sof;
    logic out_eol;
    logic out_eof;

    modport master (
        output out_valid, out_cell, out_sof, out_eol, out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_cell, out_sof, out_eol, out_eof,
        output out_ready
    );

endinterface

// File: rtl/board_scan_counter.sv
// Row-major (x,y) cursor over the board; wraps to (0,0) after the last cell.
module board_scan_counter
    import conway_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int HEIGHT = 8,
    localparam int XW     = idx_width(WIDTH),
    localparam int YW     = idx_width(HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last_col,
    output logic          o_last_cell
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_last_col  = (r_x == XW'(WIDTH - 1));
    assign o_last_cell = o_last_col && (r_y == YW'(HEIGHT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (o_last_col) begin
                r_x <= '0;
                r_y <= o_last_cell ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/board_scanout.sv
// Snapshots the next-state board and streams it one cell per beat, then reports the population.
module board_scanout
    import conway_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int HEIGHT = 8,
    localparam int CELLS  = WIDTH * HEIGHT,
    localparam int CW     = count_width(CELLS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CELLS-1:0] i_board,
    input  logic             i_snap_req,
    output logic             o_busy,
    output logic [CW-1:0]    o_alive_count,
    output logic             o_count_valid,
    board_scanout_if.master  m_out
);

    localparam int XW = idx_width(WIDTH);
    localparam int YW = idx_width(HEIGHT);

    state_e           r_state;
    logic [CELLS-1:0] r_shadow;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_alive;
    logic             r_count_valid;

    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_last_col;
    logic          w_last_cell;
    logic [CW-1:0] w_idx;
    logic          w_cell;
    logic          w_streaming;
    logic          w_start;
    logic          w_fire;

    assign w_streaming = (r_state == STREAM);
    assign w_start     = (r_state == IDLE) && i_snap_req;
    assign w_fire      = w_streaming && m_out.out_ready;
    assign w_idx       = CW'(cell_index(int'(w_x), int'(w_y), WIDTH));

    board_scan_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_counter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_start),
        .i_advance   (w_fire),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_last_col  (w_last_col),
        .o_last_cell (w_last_cell)
    );

    always_comb begin
        w_cell = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (w_idx == CW'(i)) w_cell = r_shadow[i];
        end
    end

    assign o_busy          = w_streaming;
    assign o_alive_count   = r_alive;
    assign o_count_valid   = r_count_valid;
    assign m_out.out_valid = w_streaming;
    assign m_out.out_cell  = w_streaming && w_cell;
    assign m_out.out_sof   = w_streaming && (w_x == '0) && (w_y == '0);
    assign m_out.out_eol   = w_streaming && w_last_col;
    assign m_out.out_eof   = w_streaming && w_last_cell;

    // NOTE: the shadow is a plain register bank, so it is reset along with the control state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_shadow      <= '0;
            r_count       <= '0;
            r_alive       <= '0;
            r_count_valid <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_snap_req) begin
                        r_shadow <= i_board;
                        r_count  <= '0;
                        r_state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_fire) begin
                        r_count <= r_count + CW'(w_cell);
                        if (w_last_cell) begin
                            r_alive       <= r_count + CW'(w_cell);
                            r_count_valid <= 1'b1;
                            r_state       <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_scanout.sv
// Directed bench for board_scanout: 4x3, 8x8 and 1x1 instances sharing one clock and reset.
module tb_board_scanout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [11:0] board4;
    logic        snap4, busy4, cv4;
    logic [3:0]  alive4;

    logic [63:0] board8;
    logic        snap8, busy8, cv8;
    logic [6:0]  alive8;

    logic [0:0]  board1;
    logic        snap1, busy1, cv1;
    logic [0:0]  alive1;

    board_scanout_if if4 ();
    board_scanout_if if8 ();
    board_scanout_if if1 ();

    board_scanout #(.WIDTH(4), .HEIGHT(3)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_board(board4), .i_snap_req(snap4),
        .o_busy(busy4), .o_alive_count(alive4), .o_count_valid(cv4), .m_out(if4)
    );

    board_scanout #(.WIDTH(8), .HEIGHT(8)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_board(board8), .i_snap_req(snap8),
        .o_busy(busy8), .o_alive_count(alive8), .o_count_valid(cv8), .m_out(if8)
    );

    board_scanout #(.WIDTH(1), .HEIGHT(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_board(board1), .i_snap_req(snap1),
        .o_busy(busy1), .o_alive_count(alive1), .o_count_valid(cv1), .m_out(if1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [11:0] T1_BOARD = 12'b0000_0110_0010;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Beat fields packed as {valid, cell, sof, eol, eof}.
    function automatic logic [4:0] obs4();
        return {if4.out_valid, if4.out_cell, if4.out_sof, if4.out_eol, if4.out_eof};
    endfunction

    function automatic logic [4:0] obs8();
        return {if8.out_valid, if8.out_cell, if8.out_sof, if8.out_eol, if8.out_eof};
    endfunction

    function automatic logic [4:0] obs1();
        return {if1.out_valid, if1.out_cell, if1.out_sof, if1.out_eol, if1.out_eof};
    endfunction

    function automatic logic [4:0] exp4(input int b, input logic [11:0] cells);
        return {1'b1, cells[b], b == 0, (b % 4) == 3, b == 11};
    endfunction

    task automatic stream4(input string tag, input logic [11:0] cells, input int first);
        for (int b = first; b < 12; b++) begin
            check($sformatf("%s beat %0d", tag, b), 32'(obs4()), 32'(exp4(b, cells)));
            step();
        end
    endtask

    task automatic count4(input string tag, input logic [3:0] exp_alive);
        check({tag, " done ctl"}, {29'd0, cv4, busy4, if4.out_valid}, 32'b100);
        check({tag, " alive"}, 32'(alive4), 32'(exp_alive));
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int k;

        rst_n  = 1'b0;
        board4 = '0; snap4 = 1'b0; if4.out_ready = 1'b0;
        board8 = '0; snap8 = 1'b0; if8.out_ready = 1'b0;
        board1 = '0; snap1 = 1'b0; if1.out_ready = 1'b0;

        #12;
        check("reset u4", {busy4, cv4, alive4, obs4()}, 32'd0);
        check("reset u8", {busy8, cv8, alive8, obs8()}, 32'd0);
        check("reset u1", {busy1, cv1, alive1, obs1()}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Test 1: plain frame, ready always high.
        board4 = T1_BOARD;
        if4.out_ready = 1'b1;
        snap4 = 1'b1;
        step();
        snap4 = 1'b0;
        check("t1 busy", 32'(busy4), 32'd1);
        stream4("t1", T1_BOARD, 0);
        count4("t1", 4'd3);
        check("t1 idle", {cv4, busy4, if4.out_valid}, 32'd0);
        check("t1 alive hold", 32'(alive4), 32'd3);

        // Test 2: ready pattern 1,0,0 repeating; fields must hold through stalls.
        snap4 = 1'b1;
        step();
        snap4 = 1'b0;
        b = 0;
        k = 0;
        while (b < 12 && k < 200) begin
            if4.out_ready = (k % 3 == 0);
            check($sformatf("t2 cyc %0d beat %0d", k, b), 32'(obs4()), 32'(exp4(b, T1_BOARD)));
            if (if4.out_ready) b++;
            k++;
            step();
        end
        check("t2 beats", b, 32'd12);
        check("t2 valid cycles", k, 32'd34);
        if4.out_ready = 1'b1;
        count4("t2", 4'd3);

        // Test 3: board overwritten mid-frame, snap held high across the frame boundary.
        snap4 = 1'b1;
        step();
        check("t3a beat 0", 32'(obs4()), 32'(exp4(0, T1_BOARD)));
        step();
        board4 = 12'hFFF;
        stream4("t3a", T1_BOARD, 1);
        count4("t3a", 4'd3);
        snap4 = 1'b0;
        stream4("t3b", 12'hFFF, 0);
        count4("t3b", 4'd12);

        // Test 5: reset asserted during beat 5 aborts the frame.
        board4 = T1_BOARD;
        snap4 = 1'b1;
        step();
        snap4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5 beat %0d", i), 32'(obs4()), 32'(exp4(i, T1_BOARD)));
            step();
        end
        check("t5 beat 4", 32'(obs4()), 32'(exp4(4, T1_BOARD)));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 async reset", {busy4, cv4, alive4, obs4()}, 32'd0);
        step();
        check("t5 held reset", {busy4, cv4, alive4, obs4()}, 32'd0);
        rst_n = 1'b1;
        step();
        check("t5 after release", {busy4, cv4, alive4, obs4()}, 32'd0);
        snap4 = 1'b1;
        step();
        snap4 = 1'b0;
        stream4("t5 restart", T1_BOARD, 0);
        count4("t5", 4'd3);

        // Test 4: 8x8 all ones then all zeros.
        if8.out_ready = 1'b1;
        board8 = '1;
        snap8 = 1'b1;
        step();
        snap8 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("t4 ones beat %0d", i), 32'(obs8()),
                  {27'd0, 1'b1, 1'b1, i == 0, (i % 8) == 7, i == 63});
            step();
        end
        check("t4 ones done ctl", {cv8, busy8, if8.out_valid}, 32'b100);
        check("t4 ones alive", 32'(alive8), 32'd64);
        step();
        board8 = '0;
        snap8 = 1'b1;
        step();
        snap8 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("t4 zeros beat %0d", i), 32'(obs8()),
                  {27'd0, 1'b1, 1'b0, i == 0, (i % 8) == 7, i == 63});
            step();
        end
        check("t4 zeros done ctl", {cv8, busy8, if8.out_valid}, 32'b100);
        check("t4 zeros alive", 32'(alive8), 32'd0);
        step();
        check("t4 pulse width", 32'(cv8), 32'd0);

        // Test 6: single-cell board.
        if1.out_ready = 1'b1;
        board1 = 1'b1;
        snap1 = 1'b1;
        step();
        snap1 = 1'b0;
        check("t6 beat", 32'(obs1()), 32'b11111);
        step();
        check("t6 done ctl", {cv1, busy1, if1.out_valid}, 32'b100);
        check("t6 alive", 32'(alive1), 32'd1);
        step();
        check("t6 pulse width", {cv1, busy1, if1.out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
